// File: rtl/lsu_bus_adapter_pkg.sv
// lsu_bus_adapter_pkg: shared types for the load/store bus adapter
package lsu_bus_adapter_pkg;
  typedef enum logic [1:0] {MEM_BYTE, MEM_HALF_WORD, MEM_WORD} mem_size_t;
  typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_RSP, LSU_DONE} lsu_state_t;
endpackage

// File: rtl/lsu_bus_adapter_if.sv
// lsu_bus_adapter_if: valid/ready data bus between the adapter and memory
interface lsu_bus_adapter_if;
  logic        req_valid;
  logic        req_ready;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        rsp_err;
  modport master(output req_valid, we, addr, be, wdata, input req_ready, rsp_valid, rdata, rsp_err);
  modport slave(input req_valid, we, addr, be, wdata, output req_ready, rsp_valid, rdata, rsp_err);
endinterface

// File: rtl/lsu_bus_adapter_align.sv
// lsu_bus_adapter_align: byte enables, store lane replication, load shift/extend, misalign detect
module lsu_bus_adapter_align
  import lsu_bus_adapter_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  off,
  input  logic        zero_extend,
  input  logic [31:0] wr_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rd_data,
  output logic        misaligned
);
  logic [31:0] shifted;
  // size-dependent lane steering in both directions
  always_comb begin
    shifted    = rdata >> {off, 3'b000};
    misaligned = (size == MEM_HALF_WORD && off[0]) || (size == MEM_WORD && off != 2'b00);
    be         = size == MEM_BYTE ? 4'b0001 << off : size == MEM_HALF_WORD ? 4'b0011 << off : 4'b1111;
    wdata      = size == MEM_BYTE ? {4{wr_data[7:0]}} : size == MEM_HALF_WORD ? {2{wr_data[15:0]}} : wr_data;
    rd_data    = size == MEM_BYTE ? {{24{~zero_extend & shifted[7]}}, shifted[7:0]} :
                 size == MEM_HALF_WORD ? {{16{~zero_extend & shifted[15]}}, shifted[15:0]} : shifted;
  end
endmodule

// File: rtl/lsu_bus_adapter.sv
// lsu_bus_adapter: turns one core data access into one valid/ready bus transaction
module lsu_bus_adapter
  import lsu_bus_adapter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dmem_req,
  input  logic        dmem_wr_en,
  input  mem_size_t   dmem_size,
  input  logic        dmem_zero_extend,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wr_data,
  output logic [31:0] dmem_rd_data,
  output logic        lsu_stall,
  output logic        lsu_err,
  lsu_bus_adapter_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  lsu_state_t  state;
  logic [CW-1:0] cnt;
  mem_size_t   size_q;
  logic [1:0]  off_q;
  logic        zext_q;
  logic        we_q;
  mem_size_t   a_size;
  logic [1:0]  a_off;
  logic        a_zext;
  logic [3:0]  a_be;
  logic [31:0] a_wdata;
  logic [31:0] a_rd;
  logic        a_mis;
  assign a_size    = state == LSU_IDLE ? dmem_size : size_q;
  assign a_off     = state == LSU_IDLE ? dmem_addr[1:0] : off_q;
  assign a_zext    = state == LSU_IDLE ? dmem_zero_extend : zext_q;
  assign lsu_stall = reset_n & (state == LSU_IDLE ? dmem_req : state != LSU_DONE);
  lsu_bus_adapter_align u_align (
    .size(a_size),
    .off(a_off),
    .zero_extend(a_zext),
    .wr_data(dmem_wr_data),
    .rdata(bus.rdata),
    .be(a_be),
    .wdata(a_wdata),
    .rd_data(a_rd),
    .misaligned(a_mis)
  );
  // access sequencer: issue, wait for acceptance, wait for response or timeout, hand result to core
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= LSU_IDLE;
      cnt           <= '0;
      bus.req_valid <= 1'b0;
      bus.we        <= 1'b0;
      bus.addr      <= '0;
      bus.be        <= '0;
      bus.wdata     <= '0;
      dmem_rd_data  <= '0;
      lsu_err       <= 1'b0;
      size_q        <= MEM_BYTE;
      off_q         <= '0;
      zext_q        <= 1'b0;
      we_q          <= 1'b0;
    end else begin
      case (state)
        LSU_IDLE: if (dmem_req) begin
          size_q <= dmem_size;
          off_q  <= dmem_addr[1:0];
          zext_q <= dmem_zero_extend;
          we_q   <= dmem_wr_en;
          if (a_mis) begin
            lsu_err      <= 1'b1;
            dmem_rd_data <= '0;
            state        <= LSU_DONE;
          end else begin
            bus.req_valid <= 1'b1;
            bus.we        <= dmem_wr_en;
            bus.addr      <= {dmem_addr[31:2], 2'b00};
            bus.be        <= dmem_wr_en ? a_be : 4'b0000;
            bus.wdata     <= dmem_wr_en ? a_wdata : 32'h0;
            state         <= LSU_REQ;
          end
        end
        LSU_REQ: if (bus.req_ready) begin
          bus.req_valid <= 1'b0;
          cnt           <= '0;
          state         <= LSU_RSP;
        end
        LSU_RSP: if (bus.rsp_valid) begin
          lsu_err      <= bus.rsp_err;
          dmem_rd_data <= (we_q || bus.rsp_err) ? 32'h0 : a_rd;
          state        <= LSU_DONE;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          lsu_err      <= 1'b1;
          dmem_rd_data <= '0;
          state        <= LSU_DONE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: begin
          lsu_err      <= 1'b0;
          dmem_rd_data <= '0;
          state        <= LSU_IDLE;
        end
      endcase
    end
  end
endmodule
